game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller for the Flappy Bird datapath. Turns the VGA vertical-sync into a once-per-frame tick, runs the IDLE/PLAY/DEAD game state machine from the USB keycode and the collision flag, and issues per-frame step, flap and reset strobes to the bird and pipe movers. It keeps the current and best score as 4-digit BCD for the HEX drivers. It sits between the SoC keycode PIO, `vga_controller` (vs), the bird/pipe motion blocks and the color/collision logic.

## Interface
- `FLAP_KEY`, default 8'h2C: USB HID keycode for flap/start (space).
- `PAUSE_KEY`, default 8'h13: keycode for pause ('P'); used only with `GAME_PAUSE_EN`.
- `DEAD_FRAMES`, default 60: number of frames the sequencer ignores input after death; range 1..255.
- `Clk` in 1: 50 MHz system clock; the only clock.
- `Reset` in 1: reset is synchronous and active-high.
- `frame_clk` in 1: VGA vs; asynchronous to `Clk`.
- `keycode` in 8: current key from the SoC PIO; synchronous to `Clk`.
- `collide` in 1: level signal; bird overlaps a pipe or the screen edge.
- `pipe_passed` in 1: level signal; high while the bird is past a pipe's trailing edge.
- `state` out 2: 00 IDLE, 01 PLAY, 10 DEAD, 11 PAUSE.
- `game_reset` out 1: level signal; holds the bird and pipe movers at their start positions.
- `bird_step` out 1: one-`Clk` pulse that advances bird physics by one frame.
- `pipe_step` out 1: one-`Clk` pulse that scrolls the pipes by one frame.
- `flap` out 1: one-`Clk` pulse, always coincident with `bird_step`.
- `score` out 16: BCD, 4 digits, MSD in [15:12].
- `best` out 16: BCD high score.

## Operation
- **Frame tick.** `frame_clk` passes through a 2-flop synchronizer and a rising-edge detect to give internal `tick`, one `Clk` cycle per frame.
- **Flap request.** `flap_req` is set on the `Clk` cycle where `keycode` changes from ≠`FLAP_KEY` to ==`FLAP_KEY`. It is cleared when consumed at a `tick`. Holding the key produces one request.
- **Pipe pass.** A rising edge of `pipe_passed`, sampled on `Clk`, is a pass event.
- **IDLE:**
  - `game_reset`=1; no step pulses.
  - At a `tick` with `flap_req`: go to PLAY, clear `score` to 0, drop `game_reset`, and issue `bird_step`+`flap`+`pipe_step`.
- **PLAY:**
  - At each `tick`, issue `bird_step` and `pipe_step`, plus `flap`=`flap_req`.
  - Each pass event increments `score` in BCD (digit 9 carries into the next digit). The score saturates at 9999.
  - If `collide`=1 at a `tick`: go to DEAD and issue no pulses on that tick.
  - A pass event in the same cycle as the PLAY→DEAD transition still counts.
- **DEAD:**
  - On entry, load the frame counter with `DEAD_FRAMES`. If `score`>`best` (plain 16-bit compare, valid for BCD), copy `score` into `best`.
  - Each `tick` decrements the counter. While the counter is ≠0, `flap_req` is discarded at each tick.
  - At a `tick` with counter==0 and `flap_req`: go to IDLE. `score` is kept until the next game starts.
  - Pass events are ignored.
- **Reset values:** `state`=IDLE, `game_reset`=1, all pulses 0, `score`=0, `best`=0, `flap_req`=0, synchronizer flops=0, counter=0. Reset applied mid-game also clears `best`.

## Timing
- `tick` is asserted 3 `Clk` cycles after the `frame_clk` rising edge is first sampled.
- All outputs are registered. Pulses appear 1 cycle after `tick`, so 4 cycles after the vs edge, and last exactly 1 cycle.
- A `flap_req` captured in the same cycle as `tick` is consumed by that tick.
- `score` updates 1 cycle after the pass event.
- `best` updates 1 cycle after entry to DEAD.
- At most one state transition happens per `tick`.

## Configuration
- `GAME_PAUSE_EN` defined:
  - In PLAY, a `PAUSE_KEY` press edge sets a pause request. The next `tick` moves to PAUSE (`state`=11) with no pulses; pass events are ignored in PAUSE.
  - In PAUSE, a `PAUSE_KEY` edge returns to PLAY at the next `tick`, which issues normal pulses. `flap_req` is discarded while in PAUSE.
  - `collide` is not evaluated in PAUSE.
- `GAME_PAUSE_EN` undefined: `PAUSE_KEY` is ignored, `state` never reaches 11, and no pause logic is synthesized.

## Test plan
- **Reset and idle start.** Reset, then press `keycode`=8'h2C and hold 10 frames. Expect exactly one transition to PLAY, with one `flap` pulse coinciding with the first `bird_step`. `game_reset` falls on the same cycle. Later frames show `bird_step`/`pipe_step` with `flap`=0.
- **Frame latency.** Toggle `frame_clk` asynchronously. Each vs rising edge must give exactly one `bird_step` pulse, 4 `Clk` cycles after the edge is first sampled.
- **Scoring and saturation.** Drive 12 `pipe_passed` edges: `score`=16'h0012. Preload `score` to 16'h9998 via 3 more edges: result saturates at 16'h9999.
- **Death and best score.** Reach score 16'h0007, then `collide`=1 at a tick. Expect: DEAD, no pulses on that tick, `best`=16'h0007.
- **Dead lockout.** In DEAD with `DEAD_FRAMES`=60, press flap at frame 30: stays DEAD. Press at frame 61: returns to IDLE. A second game scoring 3 leaves `best`=16'h0007.
- **Pause (with `GAME_PAUSE_EN`).** Press 8'h13 in PLAY: `state`=11 and no pulses for 20 frames. Press 8'h13 again: PLAY resumes with pulses on the next tick.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Signal bundle between the Flappy Bird game sequencer and its environment:
// VGA vs, keycode, motion-block strobes, collision flag and BCD scores.
interface game_sequencer_if;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        collide;
    logic        pipe_passed;
    logic [1:0]  state;
    logic        game_reset;
    logic        bird_step;
    logic        pipe_step;
    logic        flap;
    logic [15:0] score;
    logic [15:0] best;

    modport master (
        output frame_clk, keycode, collide, pipe_passed,
        input  state, game_reset, bird_step, pipe_step, flap, score, best
    );

    modport slave (
        input  frame_clk, keycode, collide, pipe_passed,
        output state, game_reset, bird_step, pipe_step, flap, score, best
    );
endinterface

// File: rtl/game_sequencer.sv
// Flappy Bird game controller: vs-derived frame tick, IDLE/PLAY/DEAD FSM, BCD score/best.
// Optional pause state (state 11, PAUSE_KEY) is built only when GAME_PAUSE_EN is defined.
//
// state | meaning
// IDLE  | movers held at start, waiting for a flap press
// PLAY  | per-frame bird/pipe steps, scoring pass events
// DEAD  | lockout for DEAD_FRAMES ticks, then flap returns to IDLE
// PAUSE | frozen, no pulses, until the pause key is pressed again
module game_sequencer #(
    parameter logic [7:0]  FLAP_KEY    = 8'h2C,
`ifdef GAME_PAUSE_EN
    parameter logic [7:0]  PAUSE_KEY   = 8'h13,
`endif
    parameter int unsigned DEAD_FRAMES = 60
) (
    input logic            Clk,
    input logic            Reset,
    game_sequencer_if.slave gif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_DEAD  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_FRAMES);

    logic [3:0]  vs_sync;
    logic        tick;
    logic [7:0]  key_prev;
    logic        pass_prev;
    logic        flap_edge;
    logic        pass_ev;
    logic        flap_now;
    logic        flap_req, flap_req_nxt;
    state_t      state_q, state_nxt;
    logic        game_reset_q, game_reset_nxt;
    logic        bird_step_q, bird_step_nxt;
    logic        pipe_step_q, pipe_step_nxt;
    logic        flap_q, flap_nxt;
    logic [15:0] score_q, score_nxt;
    logic [15:0] best_q;
    logic [7:0]  dead_cnt, dead_cnt_nxt;
    logic        dead_entry, dead_entry_nxt;
`ifdef GAME_PAUSE_EN
    logic        pause_edge;
    logic        pause_now;
    logic        pause_req, pause_req_nxt;
`endif

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two sync flops plus two alignment flops; tick lands 3 cycles after the edge is first sampled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_sync   <= '0;
            tick      <= 1'b0;
            key_prev  <= '0;
            pass_prev <= 1'b0;
        end else begin
            vs_sync   <= {vs_sync[2:0], gif.frame_clk};
            tick      <= vs_sync[2] & ~vs_sync[3];
            key_prev  <= gif.keycode;
            pass_prev <= gif.pipe_passed;
        end
    end

    assign flap_edge = (gif.keycode == FLAP_KEY) && (key_prev != FLAP_KEY);
    assign pass_ev   = gif.pipe_passed & ~pass_prev;
    assign flap_now  = flap_req | flap_edge;

`ifdef GAME_PAUSE_EN
    assign pause_edge = (gif.keycode == PAUSE_KEY) && (key_prev != PAUSE_KEY);
    assign pause_now  = pause_req |
                        (pause_edge && (state_q == S_PLAY || state_q == S_PAUSE));
`endif

    always_comb begin
        state_nxt      = state_q;
        bird_step_nxt  = 1'b0;
        pipe_step_nxt  = 1'b0;
        flap_nxt       = 1'b0;
        score_nxt      = score_q;
        dead_cnt_nxt   = dead_cnt;
        dead_entry_nxt = 1'b0;
        // Every tick consumes or discards a pending request, whatever the state.
        flap_req_nxt   = tick ? 1'b0 : flap_now;
`ifdef GAME_PAUSE_EN
        pause_req_nxt  = tick ? 1'b0 : pause_now;
`endif
        case (state_q)
            S_IDLE: begin
                if (tick && flap_now) begin
                    state_nxt     = S_PLAY;
                    score_nxt     = '0;
                    bird_step_nxt = 1'b1;
                    pipe_step_nxt = 1'b1;
                    flap_nxt      = 1'b1;
                end
            end
            S_PLAY: begin
                if (pass_ev) score_nxt = bcd_inc(score_q);
                if (tick) begin
                    if (gif.collide) begin
                        state_nxt      = S_DEAD;
                        dead_cnt_nxt   = DEAD_LOAD;
                        dead_entry_nxt = 1'b1;
                    end
`ifdef GAME_PAUSE_EN
                    else if (pause_now) begin
                        state_nxt = S_PAUSE;
                    end
`endif
                    else begin
                        bird_step_nxt = 1'b1;
                        pipe_step_nxt = 1'b1;
                        flap_nxt      = flap_now;
                    end
                end
            end
            S_DEAD: begin
                if (tick) begin
                    if (dead_cnt != 8'd0) begin
                        dead_cnt_nxt = dead_cnt - 8'd1;
                    end else if (flap_now) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (tick && pause_now) begin
                    state_nxt     = S_PLAY;
                    bird_step_nxt = 1'b1;
                    pipe_step_nxt = 1'b1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        game_reset_nxt = (state_nxt == S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            game_reset_q <= 1'b1;
            bird_step_q  <= 1'b0;
            pipe_step_q  <= 1'b0;
            flap_q       <= 1'b0;
            score_q      <= '0;
            best_q       <= '0;
            flap_req     <= 1'b0;
            dead_cnt     <= '0;
            dead_entry   <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_req    <= 1'b0;
`endif
        end else begin
            state_q      <= state_nxt;
            game_reset_q <= game_reset_nxt;
            bird_step_q  <= bird_step_nxt;
            pipe_step_q  <= pipe_step_nxt;
            flap_q       <= flap_nxt;
            score_q      <= score_nxt;
            flap_req     <= flap_req_nxt;
            dead_cnt     <= dead_cnt_nxt;
            dead_entry   <= dead_entry_nxt;
`ifdef GAME_PAUSE_EN
            pause_req    <= pause_req_nxt;
`endif
            // Compared one cycle after entry so a pass on the dying cycle is included.
            if (dead_entry && (score_q > best_q)) best_q <= score_q;
        end
    end

    assign gif.state      = state_q;
    assign gif.game_reset = game_reset_q;
    assign gif.bird_step  = bird_step_q;
    assign gif.pipe_step  = pipe_step_q;
    assign gif.flap       = flap_q;
    assign gif.score      = score_q;
    assign gif.best       = best_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: frame-level game model compared every cycle,
// plus directed scenarios with literal expectations (start, scoring, death, lockout, pause).
module tb_game_sequencer;

    localparam logic [7:0] FLAP_KEY    = 8'h2C;
    localparam logic [7:0] PAUSE_KEY   = 8'h13;
    localparam int         DEAD_FRAMES = 60;
`ifdef GAME_PAUSE_EN
    localparam bit         PAUSE_ON    = 1'b1;
`else
    localparam bit         PAUSE_ON    = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    game_sequencer_if gif();

    game_sequencer #(.DEAD_FRAMES(DEAD_FRAMES)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .gif   (gif)
    );

    always #5 Clk = ~Clk;

    // vs edges always fall 3 time units before a Clk rising edge, never on it.
    initial begin
        gif.frame_clk = 1'b0;
        #2;
        for (int n = 0; ; n++) begin
            #(150 + 10 * (n % 3));
            gif.frame_clk = 1'b1;
            #150;
            gif.frame_clk = 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic       s_rst, s_fc, s_col, s_pp;
    logic [7:0] s_key;
    always @(posedge Clk) begin
        s_rst <= Reset;
        s_fc  <= gif.frame_clk;
        s_key <= gif.keycode;
        s_col <= gif.collide;
        s_pp  <= gif.pipe_passed;
    end

    function automatic int bcd2int(input logic [15:0] b);
        return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Game model state
    int          m_state = 0;
    bit          m_gr = 1'b1, m_bs = 1'b0, m_ps = 1'b0, m_fl = 1'b0;
    logic [15:0] m_score = '0, m_best = '0;
    bit          m_req = 1'b0, m_preq = 1'b0, m_best_due = 1'b0;
    bit          m_fc_prev = 1'b0, m_pp_prev = 1'b0;
    logic [7:0]  m_key_prev = '0;
    int          m_dead_left = 0;
    int          m_n = 0;
    int          m_tick_due[$];

    // Observation counters used by the directed scenarios
    int step_cnt = 0, flap_cnt = 0, last_lat = -1, edge_n = 0;
    bit mon_fc_prev = 1'b0;

    initial begin : model_and_compare
        bit is_tick, fc_rise, fl_ev, pz_ev, pass, req, preq;
        int nxt, sc;
        forever begin
            @(negedge Clk);
            if (s_rst) begin
                m_state = 0; m_gr = 1'b1; m_bs = 1'b0; m_ps = 1'b0; m_fl = 1'b0;
                m_score = '0; m_best = '0; m_req = 1'b0; m_preq = 1'b0;
                m_fc_prev = 1'b0; m_pp_prev = 1'b0; m_key_prev = '0;
                m_best_due = 1'b0; m_dead_left = 0;
                m_tick_due.delete();
                mon_fc_prev = 1'b0;
            end else begin
                fc_rise   = s_fc && !m_fc_prev;
                m_fc_prev = s_fc;
                is_tick   = 1'b0;
                if (m_tick_due.size() > 0 && m_tick_due[0] == m_n) begin
                    is_tick = 1'b1;
                    void'(m_tick_due.pop_front());
                end
                if (fc_rise) m_tick_due.push_back(m_n + 4);

                if (m_best_due) begin
                    if (m_score > m_best) m_best = m_score;
                    m_best_due = 1'b0;
                end
                fl_ev      = (s_key == FLAP_KEY) && (m_key_prev != FLAP_KEY);
                pz_ev      = (s_key == PAUSE_KEY) && (m_key_prev != PAUSE_KEY);
                m_key_prev = s_key;
                pass       = s_pp && !m_pp_prev;
                m_pp_prev  = s_pp;
                req        = m_req || fl_ev;
                preq       = m_preq || (pz_ev && (m_state == 1 || m_state == 3));

                nxt = m_state; m_bs = 1'b0; m_ps = 1'b0; m_fl = 1'b0;
                if (m_state == 0) begin
                    if (is_tick && req) begin
                        nxt = 1; m_score = '0; m_bs = 1'b1; m_ps = 1'b1; m_fl = 1'b1;
                    end
                end else if (m_state == 1) begin
                    if (pass) begin
                        sc = bcd2int(m_score) + 1;
                        m_score = int2bcd(sc > 9999 ? 9999 : sc);
                    end
                    if (is_tick) begin
                        if (s_col) begin
                            nxt = 2; m_dead_left = DEAD_FRAMES; m_best_due = 1'b1;
                        end else if (PAUSE_ON && preq) begin
                            nxt = 3;
                        end else begin
                            m_bs = 1'b1; m_ps = 1'b1; m_fl = req;
                        end
                    end
                end else if (m_state == 2) begin
                    if (is_tick) begin
                        if (m_dead_left > 0) m_dead_left--;
                        else if (req) nxt = 0;
                    end
                end else begin
                    if (is_tick && preq) begin
                        nxt = 1; m_bs = 1'b1; m_ps = 1'b1;
                    end
                end
                if (is_tick) begin
                    m_req = 1'b0; m_preq = 1'b0;
                end else begin
                    m_req = req; m_preq = preq;
                end
                m_state = nxt;
                m_gr    = (nxt == 0);

                if (s_fc && !mon_fc_prev) edge_n = m_n;
                mon_fc_prev = s_fc;
            end

            check("outputs {state,game_reset,bird_step,pipe_step,flap,score,best}",
                  64'({gif.state, gif.game_reset, gif.bird_step, gif.pipe_step, gif.flap,
                       gif.score, gif.best}),
                  64'({2'(m_state), m_gr, m_bs, m_ps, m_fl, m_score, m_best}));

            if (gif.bird_step === 1'b1) begin
                step_cnt++;
                last_lat = m_n - edge_n;
            end
            if (gif.flap === 1'b1) flap_cnt++;
            m_n++;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge gif.frame_clk);
            repeat (6) @(negedge Clk);
        end
    endtask

    task automatic tap(input logic [7:0] code);
        gif.keycode = code;
        repeat (2) @(negedge Clk);
        gif.keycode = 8'h00;
        @(negedge Clk);
    endtask

    task automatic pass_pipe(input int n);
        repeat (n) begin
            gif.pipe_passed = 1'b1;
            @(negedge Clk);
            gif.pipe_passed = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic die();
        gif.collide = 1'b1;
        wait_ticks(1);
        gif.collide = 1'b0;
    endtask

    initial begin : stimulus
        int s0, f0;
        Reset           = 1'b1;
        gif.keycode     = 8'h00;
        gif.collide     = 1'b0;
        gif.pipe_passed = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset state", 64'(gif.state), 64'(2'b00));
        check("reset game_reset", 64'(gif.game_reset), 64'(1'b1));
        check("reset score", 64'(gif.score), 64'(16'h0000));
        check("reset best", 64'(gif.best), 64'(16'h0000));
        Reset = 1'b0;

        wait_ticks(2);
        check("idle without key", 64'(gif.state), 64'(2'b00));

        // Hold flap for 10 frames: one start, one flap, ten steps.
        s0 = step_cnt; f0 = flap_cnt;
        gif.keycode = FLAP_KEY;
        wait_ticks(10);
        gif.keycode = 8'h00;
        check("start state", 64'(gif.state), 64'(2'b01));
        check("held key flap count", 64'(flap_cnt - f0), 64'(1));
        check("held key step count", 64'(step_cnt - s0), 64'(10));
        check("vs to bird_step latency", 64'(last_lat), 64'(4));
        check("play game_reset", 64'(gif.game_reset), 64'(1'b0));

        // Game 1: score 7, die, best 7
        pass_pipe(7);
        check("score 7", 64'(gif.score), 64'(16'h0007));
        s0 = step_cnt;
        die();
        check("dead state", 64'(gif.state), 64'(2'b10));
        check("no pulses on death tick", 64'(step_cnt - s0), 64'(0));
        check("best after game 1", 64'(gif.best), 64'(16'h0007));

        // Lockout: presses at dead frames 30 and 60 ignored, 61 accepted
        wait_ticks(29);
        tap(FLAP_KEY);
        wait_ticks(1);
        check("dead frame 30 press", 64'(gif.state), 64'(2'b10));
        wait_ticks(29);
        tap(FLAP_KEY);
        wait_ticks(1);
        check("dead frame 60 press", 64'(gif.state), 64'(2'b10));
        tap(FLAP_KEY);
        wait_ticks(1);
        check("dead frame 61 press", 64'(gif.state), 64'(2'b00));
        check("score kept in idle", 64'(gif.score), 64'(16'h0007));
        check("idle game_reset", 64'(gif.game_reset), 64'(1'b1));

        // Game 2: pause behaviour, then score 3
        tap(FLAP_KEY);
        wait_ticks(1);
        check("game 2 start", 64'(gif.state), 64'(2'b01));
        check("game 2 score cleared", 64'(gif.score), 64'(16'h0000));
`ifdef GAME_PAUSE_EN
        tap(PAUSE_KEY);
        wait_ticks(1);
        check("paused state", 64'(gif.state), 64'(2'b11));
        s0 = step_cnt;
        tap(FLAP_KEY);
        wait_ticks(20);
        check("no steps while paused", 64'(step_cnt - s0), 64'(0));
        check("still paused", 64'(gif.state), 64'(2'b11));
        tap(PAUSE_KEY);
        wait_ticks(1);
        check("resume state", 64'(gif.state), 64'(2'b01));
        check("resume step", 64'(step_cnt - s0), 64'(1));
`else
        tap(PAUSE_KEY);
        s0 = step_cnt;
        wait_ticks(1);
        check("pause key ignored", 64'(gif.state), 64'(2'b01));
        check("step after pause key", 64'(step_cnt - s0), 64'(1));
`endif
        pass_pipe(3);
        check("score 3", 64'(gif.score), 64'(16'h0003));
        die();
        check("best kept at 7", 64'(gif.best), 64'(16'h0007));
        wait_ticks(60);
        tap(FLAP_KEY);
        wait_ticks(1);
        check("back to idle", 64'(gif.state), 64'(2'b00));

        // Game 3: BCD carries and saturation
        tap(FLAP_KEY);
        wait_ticks(1);
        pass_pipe(12);
        check("score 12", 64'(gif.score), 64'(16'h0012));
        pass_pipe(9986);
        check("score 9998", 64'(gif.score), 64'(16'h9998));
        pass_pipe(3);
        check("score saturated", 64'(gif.score), 64'(16'h9999));
        die();
        check("best 9999", 64'(gif.best), 64'(16'h9999));

        // Reset with a best on record clears it
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset clears best", 64'(gif.best), 64'(16'h0000));
        check("reset state again", 64'(gif.state), 64'(2'b00));
        wait_ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
